uart_line_scheduler: RTL and testbench

Shares one UART transmitter between several value producers: duration timers, counters, and other monitors. It grants one requester at a time, round-robin, and latches that requester's 16-bit value. It converts the value to five BCD digits with an internal sequential double-dabble, then streams a fixed 9-byte ASCII line to the UART byte by byte. It sits between the monitor blocks and the existing `uart` instance, replacing free-running character-counter sequencing with a request/ack scheme.

---
 rtl/uart_line_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_line_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_scheduler.sv
// uart_line_scheduler
// Shares one UART transmitter between several value producers. A round-robin
// arbiter grants one requester at a time, latches its 16-bit value, converts
// it to five BCD digits with a sequential double dabble, then streams the
// 9-byte ASCII line "<ch>:<d4><d3><d2><d1><d0>\r\n" to the uart byte by byte.
//
// Handshake: a requester raises req[k] with value[k] stable and keeps both
// until it sees the one-cycle ack[k] pulse; ack[k] marks the cycle after the
// value was latched, so the requester may change or drop them from then on.
// Toward the uart, uart_wr is a one-cycle strobe issued only while uart_busy
// is low; uart_dat is meaningful only in that strobe cycle.

module uart_line_scheduler #(
  parameter int NUMBER_OF_CHANNELS = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUMBER_OF_CHANNELS-1:0]     req,
  input  logic [16*NUMBER_OF_CHANNELS-1:0]  value,
  output logic [NUMBER_OF_CHANNELS-1:0]     ack,
  input  logic                              uart_busy,
  output logic                              uart_wr,
  output logic [7:0]                        uart_dat,
  output logic                              busy,
  output logic [2:0]                        state_dbg
);

  localparam int N = NUMBER_OF_CHANNELS;
  localparam logic [3:0] LAST_CH = 4'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SEND    = 3'd2,
    S_HOLD    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  pointer;
  logic [3:0]  chan;
  logic [3:0]  index;
  logic [3:0]  dd_count;
  logic [19:0] bcd;
  logic [15:0] shreg;

  logic          grant_found;
  logic [3:0]    grant_idx;
  logic [N-1:0]  grant_onehot;
  logic [15:0]   grant_value;
  logic [19:0]   bcd_adj;
  logic [7:0]    line_byte;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Round-robin pick: lowest requester at or above pointer, else lowest overall.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    grant_value  = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_found && req[i] && (4'(i) >= pointer)) begin
        grant_found     = 1'b1;
        grant_idx       = 4'(i);
        grant_onehot[i] = 1'b1;
        grant_value     = value[16*i +: 16];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_found && req[i]) begin
        grant_found     = 1'b1;
        grant_idx       = 4'(i);
        grant_onehot[i] = 1'b1;
        grant_value     = value[16*i +: 16];
      end
    end
  end

  // Double-dabble correction: add 3 to every BCD nybble of 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 5; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Byte of the output line selected by the current index.
  always_comb begin
    line_byte = 8'h00;
    case (index)
      4'd0:    line_byte = 8'h30 + {4'h0, chan};
      4'd1:    line_byte = 8'h3A;
      4'd2:    line_byte = {4'h3, bcd[19:16]};
      4'd3:    line_byte = {4'h3, bcd[15:12]};
      4'd4:    line_byte = {4'h3, bcd[11:8]};
      4'd5:    line_byte = {4'h3, bcd[7:4]};
      4'd6:    line_byte = {4'h3, bcd[3:0]};
      4'd7:    line_byte = 8'h0D;
      4'd8:    line_byte = 8'h0A;
      default: line_byte = 8'h00;
    endcase
  end

  // Line sequencer: grant, convert, then send/hold/drain each of the 9 bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pointer  <= '0;
      chan     <= '0;
      index    <= '0;
      dd_count <= '0;
      bcd      <= '0;
      shreg    <= '0;
      ack      <= '0;
      uart_wr  <= 1'b0;
      uart_dat <= 8'h00;
    end else begin
      ack      <= '0;
      uart_wr  <= 1'b0;
      uart_dat <= 8'h00;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            ack      <= grant_onehot;
            chan     <= grant_idx;
            shreg    <= grant_value;
            bcd      <= '0;
            dd_count <= '0;
            pointer  <= (grant_idx == LAST_CH) ? 4'd0 : grant_idx + 4'd1;
            state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          // One shift per cycle; the sixteenth shift completes the conversion.
          {bcd, shreg} <= {bcd_adj[18:0], shreg, 1'b0};
          dd_count     <= dd_count + 4'd1;
          if (dd_count == 4'd15) begin
            index <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!uart_busy) begin
            uart_wr  <= 1'b1;
            uart_dat <= line_byte;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // The uart raises busy one cycle after the strobe, so it is not
          // trustworthy here.
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!uart_busy) begin
            if (index == 4'd8) begin
              state <= S_IDLE;
            end else begin
              index <= index + 4'd1;
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_scheduler.sv
// Bench for uart_line_scheduler: directed scenarios plus randomized request
// batches, checked by a scoreboard fed from a round-robin reference model.

module tb_uart_line_scheduler;

  localparam int NCH = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NCH-1:0]      req   = '0;
  logic [16*NCH-1:0]   value = '0;
  logic [NCH-1:0]      ack;
  logic                uart_busy;
  logic                uart_wr;
  logic [7:0]          uart_dat;
  logic                busy;
  logic [2:0]          state_dbg;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [7:0] exp_q[$];
  int         exp_ack_q[$];

  int pend[NCH];
  int vals[NCH];
  int pred_cnt[NCH];
  int ptr_m = 0;

  int   ucnt      = 0;
  logic stall     = 1'b0;
  logic rand_busy = 1'b0;

  uart_line_scheduler #(.NUMBER_OF_CHANNELS(NCH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .value     (value),
    .ack       (ack),
    .uart_busy (uart_busy),
    .uart_wr   (uart_wr),
    .uart_dat  (uart_dat),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  // uart model: busy rises the cycle after a strobe, for a number of cycles
  always @(posedge clock) begin
    if (uart_wr) ucnt <= rand_busy ? int'($urandom_range(1, 12)) : 10;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign uart_busy = (ucnt != 0) || stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // reference model: expected bytes of one line, from plain decimal arithmetic
  task automatic push_line(input int k, input int v);
    int div;
    exp_ack_q.push_back(k);
    exp_q.push_back(8'(48 + k));
    exp_q.push_back(8'h3A);
    div = 10000;
    for (int d = 0; d < 5; d++) begin
      exp_q.push_back(8'(48 + (v / div) % 10));
      div = div / 10;
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // reference model: round-robin service order over the requests in pred_cnt
  task automatic predict();
    int total = 0;
    for (int k = 0; k < NCH; k++) total += pred_cnt[k];
    while (total > 0) begin
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (ptr_m + i) % NCH;
        if (pred_cnt[k] > 0) begin
          push_line(k, vals[k]);
          pred_cnt[k]--;
          total--;
          ptr_m = (k + 1) % NCH;
          break;
        end
      end
    end
  endtask

  // driver tasks
  task automatic raise(input int k, input int cnt, input int v);
    vals[k] = v;
    value[16*k +: 16] = 16'(v);
    pend[k] = cnt;
    req[k]  = 1'b1;
  endtask

  task automatic wait_ack(input string name, output int at);
    int t = 0;
    at = -1;
    while (t < 200) begin
      @(negedge clock);
      t++;
      if (ack != '0) begin
        at = cycle;
        break;
      end
    end
    check({name, "_ack_seen"}, 32'(at >= 0), 1);
  endtask

  task automatic wait_strobes(input string name, input int n, output int last);
    int got = 0;
    int t = 0;
    last = -1;
    while (got < n && t < 3000) begin
      @(negedge clock);
      t++;
      if (uart_wr) begin
        got++;
        last = cycle;
      end
    end
    check({name, "_strobes_seen"}, 32'(got), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(req == '0 && busy == 1'b0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_idle_reached"}, 32'(n < 20000), 1);
    check({name, "_bytes_left"}, 32'(exp_q.size()), 0);
    check({name, "_lines_left"}, 32'(exp_ack_q.size()), 0);
  endtask

  // requester side: drop req once every pending request has been acked
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        if (ack[k]) begin
          pend[k]--;
          if (pend[k] <= 0) req[k] = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor
  logic prev_wr  = 1'b0;
  logic prev_ack = 1'b0;
  logic fresh    = 1'b1;
  int   line_strobes = 0;
  int   ack_cycle    = 0;
  always @(negedge clock) begin
    int e;
    logic [7:0] eb;
    if (reset) begin
      fresh    = 1'b1;
      prev_wr  = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (ack != '0) begin
        if (exp_ack_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 0);
        end else begin
          e = exp_ack_q.pop_front();
          check("ack_channel", 32'(ack), 32'(1) << e);
        end
        check("busy_with_ack", 32'(busy), 1);
        check("ack_width", 32'(prev_ack), 0);
        if (!fresh) check("line_length", 32'(line_strobes), 9);
        fresh        = 1'b0;
        line_strobes = 0;
        ack_cycle    = cycle;
      end
      if (uart_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got byte %0h expected no strobe (cycle %0d)", uart_dat, cycle);
        end else begin
          eb = exp_q.pop_front();
          check("line_byte", 32'(uart_dat), 32'(eb));
        end
        if (line_strobes == 0 && !fresh) check("first_strobe_latency", 32'(cycle - ack_cycle), 17);
        check("strobe_while_uart_busy", 32'(uart_busy), 0);
        check("strobe_back_to_back", 32'(prev_wr), 0);
        line_strobes++;
      end
      prev_wr  = uart_wr;
      prev_ack = (ack != '0);
    end
  end

  // watchdog
  initial begin
    repeat (90000) @(posedge clock);
    errors++;
    $display("FAIL watchdog: got no completion expected finish within 90000 cycles");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int t0, at, s, rel, v;
    int cnt[NCH];
    for (int k = 0; k < NCH; k++) begin
      pend[k] = 0;
      vals[k] = 0;
      pred_cnt[k] = 0;
    end

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_ack", 32'(ack), 0);
    check("reset_uart_wr", 32'(uart_wr), 0);
    check("reset_uart_dat", 32'(uart_dat), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_state", 32'(state_dbg), 0);
    reset = 1'b0;

    // single line on channel 2
    @(negedge clock);
    raise(2, 1, 12345);
    pred_cnt = '{0, 0, 1, 0};
    predict();
    t0 = cycle;
    wait_ack("single", at);
    check("grant_latency", 32'(at - t0), 1);
    wait_strobes("single", 9, s);
    t0 = 0;
    while (busy && t0 < 100) begin
      @(negedge clock);
      t0++;
    end
    check("busy_fall_after_drain", 32'(cycle - s), 12);
    wait_idle("single");

    // extremes
    raise(0, 1, 0);
    pred_cnt = '{1, 0, 0, 0};
    predict();
    wait_idle("zero");
    raise(3, 1, 65535);
    pred_cnt = '{0, 0, 0, 1};
    predict();
    wait_idle("max");

    // fairness: all held high, then only channel 1
    for (int k = 0; k < NCH; k++) raise(k, (k == 0) ? 2 : 1, int'($urandom_range(0, 65535)));
    pred_cnt = '{2, 1, 1, 1};
    predict();
    wait_idle("fair_all");
    raise(1, 1, int'($urandom_range(0, 65535)));
    pred_cnt = '{0, 1, 0, 0};
    predict();
    wait_idle("fair_one");

    // uart stall after the third byte
    raise(2, 1, int'($urandom_range(0, 65535)));
    pred_cnt = '{0, 0, 1, 0};
    predict();
    wait_strobes("stall_pre", 3, s);
    @(posedge clock);
    #1 stall = 1'b1;
    repeat (200) @(negedge clock);
    stall = 1'b0;
    rel = cycle;
    wait_strobes("stall_post", 1, s);
    check("stall_resume", 32'(s - rel), 2);
    wait_idle("stall");

    // reset in the middle of a line with channels 1 and 3 pending
    raise(2, 1, int'($urandom_range(0, 65535)));
    pred_cnt = '{0, 0, 1, 0};
    predict();
    wait_ack("midreset", at);
    raise(1, 1, int'($urandom_range(0, 65535)));
    raise(3, 1, int'($urandom_range(0, 65535)));
    wait_strobes("midreset", 5, s);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_ack", 32'(ack), 0);
    check("midreset_uart_wr", 32'(uart_wr), 0);
    check("midreset_uart_dat", 32'(uart_dat), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_state", 32'(state_dbg), 0);
    exp_q.delete();
    exp_ack_q.delete();
    ptr_m = 0;
    pred_cnt = '{0, 1, 0, 1};
    predict();
    reset = 1'b0;
    wait_idle("after_reset");

    // value change on the granted channel and a new request during CONVERT
    v = int'($urandom_range(0, 65535));
    raise(2, 1, v);
    pred_cnt = '{0, 0, 1, 0};
    predict();
    wait_ack("midchange", at);
    repeat (3) @(negedge clock);
    value[16*2 +: 16] = ~16'(v);
    raise(0, 1, int'($urandom_range(0, 65535)));
    pred_cnt = '{1, 0, 0, 0};
    predict();
    wait_idle("midchange");

    // randomized batches with varying uart busy time
    rand_busy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < NCH; k++) cnt[k] = int'($urandom_range(0, 2));
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(0, NCH - 1)] = 1;
      for (int k = 0; k < NCH; k++) begin
        if (cnt[k] > 0) raise(k, cnt[k], int'($urandom_range(0, 65535)));
        pred_cnt[k] = cnt[k];
      end
      predict();
      wait_idle("random_batch");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
